// File: rtl/bus_arbiter2.sv
// ============================================================================
// bus_arbiter2
// ----------------------------------------------------------------------------
// Two-requester bus arbiter with round-robin fairness and a shared data mux.
// A request is granted one cycle after it is sampled. The owner keeps the bus
// for as long as it holds its request. When a grant ends, priority passes to
// the other requester. If the other requester is waiting, it receives the bus
// on the next edge with no idle cycle in between.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   A hold counter limits each grant to MAX_HOLD cycles while the other
//   requester is waiting. When the limit is hit, ownership is forcibly handed
//   over, timeout pulses for one cycle, and priority returns to the requester
//   that was preempted. With the macro undefined, no counter exists and
//   timeout is tied low. The port list is the same in both builds.
//
// Parameters:
//   DATA_W   - width of the shared data path
//   MAX_HOLD - grant length limit in cycles (used only with ARB_TIMEOUT_EN)
//
// Ports:
//   clk     in   clock, all state changes on the rising edge
//   rst     in   synchronous active-high reset
//   reqA    in   requester A wants the bus
//   reqB    in   requester B wants the bus
//   A       in   requester A data [DATA_W]
//   B       in   requester B data [DATA_W]
//   gntA    out  A owns the bus (registered)
//   gntB    out  B owns the bus (registered)
//   sel     out  mux select, 0 = A, 1 = B (registered, held while idle)
//   out     out  shared bus: B when sel = 1, otherwise A [DATA_W]
//   busy    out  either grant is high
//   timeout out  one-cycle pulse on a forced preemption
// ============================================================================
module bus_arbiter2 #(
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reqA,
    input  logic              reqB,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              gntA,
    output logic              gntB,
    output logic              sel,
    output logic [DATA_W-1:0] out,
    output logic              busy,
    output logic              timeout
);

    // A limit below one cycle makes no sense; reject it at elaboration.
    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("bus_arbiter2: MAX_HOLD must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   prio_q,  prio_d;    // 0 = A wins a tie, 1 = B wins a tie
    logic   sel_q,   sel_d;
    logic   gnt_a_q, gnt_a_d;
    logic   gnt_b_q, gnt_b_d;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    // hold_q counts the cycles of the current grant that have already
    // completed, so the current cycle is cycle number hold_q + 1. The limit
    // is reached when the current cycle is the MAX_HOLD-th one. The counter
    // saturates at MAX_HOLD, which keeps the comparison true for as long as
    // nobody else is waiting.
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             timeout_q, timeout_d;
    logic             hold_expired;

    assign hold_expired = (hold_q >= CNT_W'(MAX_HOLD - 1));
`endif

    // Next-state logic. Priority changes whenever a grant ends. On a
    // voluntary release, priority goes to the other side. On a forced
    // preemption, priority goes back to the side that lost the bus.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
`ifdef ARB_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (reqA && reqB) begin
                    state_d = prio_q ? OWN_B : OWN_A;
                end else if (reqA) begin
                    state_d = OWN_A;
                end else if (reqB) begin
                    state_d = OWN_B;
                end
            end
            OWN_A: begin
                if (!reqA) begin
                    prio_d  = 1'b1;
                    state_d = reqB ? OWN_B : IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_expired && reqB) begin
                    prio_d    = 1'b0;
                    state_d   = OWN_B;
                    timeout_d = 1'b1;
                end
`endif
            end
            OWN_B: begin
                if (!reqB) begin
                    prio_d  = 1'b0;
                    state_d = reqA ? OWN_A : IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_expired && reqA) begin
                    prio_d    = 1'b1;
                    state_d   = OWN_A;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Grants and select are registered copies of the next state. Select
        // keeps its last value while idle, so the bus does not glitch
        // between transactions.
        gnt_a_d = (state_d == OWN_A);
        gnt_b_d = (state_d == OWN_B);
        if (state_d == OWN_A) begin
            sel_d = 1'b0;
        end else if (state_d == OWN_B) begin
            sel_d = 1'b1;
        end else begin
            sel_d = sel_q;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // The counter restarts on every change of ownership, including a change
    // to idle. While the bus stays idle, the counter holds at zero.
    always_comb begin
        hold_d = hold_q;
        if (state_d != state_q) begin
            hold_d = '0;
        end else if ((state_q != IDLE) && (hold_q != CNT_W'(MAX_HOLD))) begin
            hold_d = hold_q + 1'b1;
        end
    end
`endif

    // Single state register for the whole arbiter. Reset overrides every
    // transition, so a grant in progress is released on the reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            sel_q     <= 1'b0;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            sel_q     <= sel_d;
            gnt_a_q   <= gnt_a_d;
            gnt_b_q   <= gnt_b_d;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign gntA = gnt_a_q;
    assign gntB = gnt_b_q;
    assign sel  = sel_q;
    assign busy = gnt_a_q | gnt_b_q;
    assign out  = sel_q ? B : A;

`ifdef ARB_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule
